// File: rtl/mul_pkg.sv
// mul_pkg: shared helpers for the array multiplier pipeline.
//   payload_width : bits carried across one register boundary {acc, Q, B, R, valid}
//   stage_mask    : which register boundaries are enabled (lowest index first)
package mul_pkg;
    localparam int MAX_MASK_WIDTH = 64;

    function automatic int payload_width(input int dw);
        return 5 * dw + 1;
    endfunction

    // Fractional bits do not move any boundary; the argument keeps the mask
    // signature identical to the divider's.
    function automatic logic [MAX_MASK_WIDTH-1:0] stage_mask(input int dw, input int unused_frac_bits, input int nps);
        logic [MAX_MASK_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_MASK_WIDTH; i++)
            m[i] = (i < nps) && (i < dw + 2);
        return m;
    endfunction
endpackage

// File: rtl/array_multiplier_if.sv
// array_multiplier_if: operand/result bundle of the array multiplier.
//   master : drives i_valid, Q, B, R; receives o_valid, P_out, A_out
//   slave  : the multiplier side
interface array_multiplier_if #(parameter int DATAWIDTH = 4);
    logic                     i_valid;
    logic [DATAWIDTH-1:0]     Q;
    logic [DATAWIDTH-1:0]     B;
    logic [DATAWIDTH-1:0]     R;
    logic                     o_valid;
    logic [2*DATAWIDTH-1:0]   P_out;
    logic [DATAWIDTH-1:0]     A_out;

    modport master (output i_valid, Q, B, R, input o_valid, P_out, A_out);
    modport slave  (input i_valid, Q, B, R, output o_valid, P_out, A_out);
endinterface

// File: rtl/array_multiplier_stage_comb.sv
// mul_stage_comb: one combinational slot of the array multiplier.
//   p_in, p_out : payload {acc, Q, B, R, valid}
//   ADD_R=0 : acc = (acc << 1) + (Q[BIT_POS] ? B : 0)   (MSB-first shift-add)
//   ADD_R=1 : acc = acc + R                              (final addend slot)
module mul_stage_comb import mul_pkg::*; #(
    parameter int DATAWIDTH = 4,
    parameter int BIT_POS   = 0,
    parameter bit ADD_R     = 1'b0
) (
    input  logic [payload_width(DATAWIDTH)-1:0] p_in,
    output logic [payload_width(DATAWIDTH)-1:0] p_out
);
    localparam int N = DATAWIDTH;

    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   q;
    logic [N-1:0]   b;
    logic [N-1:0]   r;
    logic           v;

    assign {acc, q, b, r, v} = p_in;

    always_comb begin
        acc_next = ADD_R ? acc + {{N{1'b0}}, r}
                         : (acc << 1) + (q[BIT_POS] ? {{N{1'b0}}, b} : '0);
        p_out    = {acc_next, q, b, r, v};
    end
endmodule

// File: rtl/pipeline_stage.sv
// pipeline_stage: optional register boundary with selectable reset polarity.
//   clk, rst : clock and synchronous reset (active-low when RST_ACTIVE_LOW=1)
//   d, q     : payload in/out; q follows d combinationally when ENABLE=0
module pipeline_stage #(
    parameter int WIDTH          = 1,
    parameter bit ENABLE         = 1'b1,
    parameter bit RST_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (ENABLE) begin : g_reg
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        always_comb data_d = d;
        always_ff @(posedge clk) begin
            if (rst == !RST_ACTIVE_LOW)
                data_q <= '0;
            else
                data_q <= data_d;
        end
        assign q = data_q;
    end else begin : g_bypass
        logic unused_ctl;
        assign unused_ctl = clk ^ rst;
        assign q = d;
    end
endmodule

// File: rtl/array_multiplier.sv
// array_multiplier: pipelined shift-add multiplier computing P = Q*B + R.
//   clk, rst : clock and synchronous active-low reset
//   bus      : slave side of array_multiplier_if
//              (i_valid, Q, B, R in; o_valid, P_out, A_out = P_out >> FRAC_BITS out)
module array_multiplier import mul_pkg::*; #(
    parameter int DATAWIDTH           = 4,
    parameter int FRAC_BITS           = 0,
    parameter int NUM_PIPELINE_STAGES = 1,
    parameter int INSTANCE_ID         = 0
) (
    input  logic               clk,
    input  logic               rst,
    array_multiplier_if.slave  bus
);
    localparam int N  = DATAWIDTH;
    localparam int PW = payload_width(N);
    localparam int NB = N + 2;
    localparam logic [MAX_MASK_WIDTH-1:0] MASK = stage_mask(N, FRAC_BITS, NUM_PIPELINE_STAGES);

    // stage_in[i] enters boundary i, stage_out[i] leaves it and feeds slot i.
    logic [PW-1:0] stage_in  [NB];
    logic [PW-1:0] stage_out [NB];

    assign stage_in[0] = {{(2*N){1'b0}}, bus.Q, bus.B, bus.R, bus.i_valid};

    for (genvar i = 0; i < NB; i++) begin : g_bnd
        pipeline_stage #(.WIDTH(PW), .ENABLE(MASK[i]), .RST_ACTIVE_LOW(1'b1)) u_reg (
            .clk (clk),
            .rst (rst),
            .d   (stage_in[i]),
            .q   (stage_out[i])
        );
    end

    for (genvar k = 0; k <= N; k++) begin : g_slot
        mul_stage_comb #(
            .DATAWIDTH (N),
            .BIT_POS   ((k < N) ? N - 1 - k : 0),
            .ADD_R     (k == N)
        ) u_slot (
            .p_in  (stage_out[k]),
            .p_out (stage_in[k+1])
        );
    end

    logic [2*N-1:0] acc_fin;
    logic [3*N-1:0] unused_fields;
    logic           valid_fin;
    logic           o_valid;

    assign {acc_fin, unused_fields, valid_fin} = stage_out[NB-1];

    // Gating with rst keeps o_valid low while reset is held, which also covers
    // the purely combinational configuration where no register clears.
    assign o_valid     = valid_fin & rst;
    assign bus.o_valid = o_valid;
    assign bus.P_out   = o_valid ? acc_fin : '0;
    assign bus.A_out   = o_valid ? N'(acc_fin >> FRAC_BITS) : '0;
endmodule
